// File: rtl/vm2002_common_pkg.sv
// vm2002 shared types: coin codes, change FSM states, coin values.
// Imported by the change controller and its coin inventory.
package vm2002_common_pkg;

  typedef enum logic [1:0] {
    NO_COINS = 2'd0,
    NICKEL   = 2'd1,
    DIME     = 2'd2,
    QUARTER  = 2'd3
  } coins_t;

  typedef enum int unsigned {
    C_IDLE_IDX     = 0,
    C_SELECT_IDX   = 1,
    C_DISPENSE_IDX = 2,
    C_DONE_IDX     = 3,
    C_SHORT_IDX    = 4
  } chg_state_idx_t;

  typedef enum logic [4:0] {
    C_IDLE     = 5'b00001,
    C_SELECT   = 5'b00010,
    C_DISPENSE = 5'b00100,
    C_DONE     = 5'b01000,
    C_SHORT    = 5'b10000
  } chg_state_t;

  localparam int NICKEL_UNITS  = 1;
  localparam int DIME_UNITS    = 2;
  localparam int QUARTER_UNITS = 5;

  function automatic logic [7:0] coin_units(input coins_t c);
    logic [7:0] u;
    u = 8'd0;
    unique case (c)
      NICKEL:  u = 8'(NICKEL_UNITS);
      DIME:    u = 8'(DIME_UNITS);
      QUARTER: u = 8'(QUARTER_UNITS);
      default: u = 8'd0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/vm2002_coin_inventory.sv
// vm2002 coin inventory: three counters with restock and one-hot decrement.
// Ports: restock (reload to *_INIT), dec_oh {Q,D,N}, counts, nonzero flags.
module vm2002_coin_inventory #(
  parameter int CNT_W  = 6,
  parameter int Q_INIT = 20,
  parameter int D_INIT = 20,
  parameter int N_INIT = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restock,
  input  logic [2:0]       dec_oh,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt,
  output logic             q_nz,
  output logic             d_nz,
  output logic             n_nz
);

  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic [CNT_W-1:0] n_cnt_q, n_cnt_d;

  // Restock and a decrement never coincide: restock is only
  // passed in while idle, decrements only happen on an ack.
  always_comb begin
    q_cnt_d = q_cnt_q;
    d_cnt_d = d_cnt_q;
    n_cnt_d = n_cnt_q;
    if (restock) begin
      q_cnt_d = CNT_W'(Q_INIT);
      d_cnt_d = CNT_W'(D_INIT);
      n_cnt_d = CNT_W'(N_INIT);
    end else begin
      if (dec_oh[2]) q_cnt_d = q_cnt_q - CNT_W'(1);
      if (dec_oh[1]) d_cnt_d = d_cnt_q - CNT_W'(1);
      if (dec_oh[0]) n_cnt_d = n_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_cnt_q <= CNT_W'(Q_INIT);
      d_cnt_q <= CNT_W'(D_INIT);
      n_cnt_q <= CNT_W'(N_INIT);
    end else begin
      q_cnt_q <= q_cnt_d;
      d_cnt_q <= d_cnt_d;
      n_cnt_q <= n_cnt_d;
    end
  end

  assign q_cnt = q_cnt_q;
  assign d_cnt = d_cnt_q;
  assign n_cnt = n_cnt_q;
  assign q_nz  = |q_cnt_q;
  assign d_nz  = |d_cnt_q;
  assign n_nz  = |n_cnt_q;

endmodule

// File: rtl/vm2002_change_ctrl.sv
// vm2002 change controller: greedy Q/D/N selection, hopper valid/ack.
// Ports: change_req/amt, restock, coin_ack in; coin_valid/type, busy,
// change_done/short, residual, q/d/n_cnt out.
// Option VM2002_HOPPER_TIMEOUT_EN: abort to C_SHORT after TIMEOUT
// cycles without coin_ack.
module vm2002_change_ctrl
  import vm2002_common_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int Q_INIT  = 20,
  parameter int D_INIT  = 20,
  parameter int N_INIT  = 20,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             change_req,
  input  logic [7:0]       change_amt,
  input  logic             restock,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic [1:0]       coin_type,
  output logic             busy,
  output logic             change_done,
  output logic             change_short,
  output logic [7:0]       residual,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt
);

  chg_state_t state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] residual_q, residual_d;
  coins_t     coin_type_q, coin_type_d;
  logic       coin_valid_q, coin_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       short_q, short_d;

  logic       q_nz, d_nz, n_nz;
  logic [2:0] dec_oh;
  logic       restock_en;
  coins_t     pick;
  logic       to_hit;

  assign restock_en = restock && (state_q == C_IDLE);

  vm2002_coin_inventory #(
    .CNT_W  (CNT_W),
    .Q_INIT (Q_INIT),
    .D_INIT (D_INIT),
    .N_INIT (N_INIT)
  ) u_inv (
    .clk     (clk),
    .rst_n   (rst_n),
    .restock (restock_en),
    .dec_oh  (dec_oh),
    .q_cnt   (q_cnt),
    .d_cnt   (d_cnt),
    .n_cnt   (n_cnt),
    .q_nz    (q_nz),
    .d_nz    (d_nz),
    .n_nz    (n_nz)
  );

  // Largest coin that fits and is in stock; no backtracking.
  always_comb begin
    pick = NO_COINS;
    if (rem_q >= 8'(QUARTER_UNITS) && q_nz) begin
      pick = QUARTER;
    end else if (rem_q >= 8'(DIME_UNITS) && d_nz) begin
      pick = DIME;
    end else if (rem_q >= 8'(NICKEL_UNITS) && n_nz) begin
      pick = NICKEL;
    end
  end

`ifdef VM2002_HOPPER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts completed wait cycles; hit on the TIMEOUT-th one.
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d = '0;
    if (state_q == C_DISPENSE && state_d == C_DISPENSE) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    residual_d  = residual_q;
    coin_type_d = coin_type_q;
    dec_oh      = 3'b000;
    unique case (1'b1)
      state_q[C_IDLE_IDX]: begin
        if (change_req) begin
          rem_d   = change_amt;
          state_d = C_SELECT;
        end
      end
      state_q[C_SELECT_IDX]: begin
        if (rem_q == 8'd0) begin
          state_d = C_DONE;
        end else if (pick != NO_COINS) begin
          coin_type_d = pick;
          state_d     = C_DISPENSE;
        end else begin
          state_d = C_SHORT;
        end
      end
      state_q[C_DISPENSE_IDX]: begin
        if (coin_ack) begin
          rem_d       = rem_q - coin_units(coin_type_q);
          dec_oh[2]   = (coin_type_q == QUARTER);
          dec_oh[1]   = (coin_type_q == DIME);
          dec_oh[0]   = (coin_type_q == NICKEL);
          coin_type_d = NO_COINS;
          state_d     = C_SELECT;
        end else if (to_hit) begin
          coin_type_d = NO_COINS;
          state_d     = C_SHORT;
        end
      end
      state_q[C_DONE_IDX]: begin
        state_d = C_IDLE;
      end
      state_q[C_SHORT_IDX]: begin
        state_d = C_IDLE;
      end
      default: begin
        state_d     = C_IDLE;
        coin_type_d = NO_COINS;
      end
    endcase

    if (state_d == C_DONE) begin
      residual_d = 8'd0;
    end else if (state_d == C_SHORT) begin
      residual_d = rem_q;
    end

    // Outputs are registered from the next state.
    coin_valid_d = (state_d == C_DISPENSE);
    busy_d       = (state_d != C_IDLE);
    done_d       = (state_d == C_DONE);
    short_d      = (state_d == C_SHORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_IDLE;
      rem_q        <= 8'd0;
      residual_q   <= 8'd0;
      coin_type_q  <= NO_COINS;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      residual_q   <= residual_d;
      coin_type_q  <= coin_type_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      short_q      <= short_d;
    end
  end

  assign coin_valid   = coin_valid_q;
  assign coin_type    = coin_type_q;
  assign busy         = busy_q;
  assign change_done  = done_q;
  assign change_short = short_q;
  assign residual     = residual_q;

endmodule

// File: tb/tb_vm2002_change_ctrl.sv
// Testbench for vm2002_change_ctrl: directed scenarios plus random
// requests against a greedy change model.
module tb_vm2002_change_ctrl;
  import vm2002_common_pkg::*;

  localparam int CNT_W = 6;
  localparam int TMO   = 64;

  logic             clk;
  logic             rst_n;
  logic             change_req;
  logic [7:0]       change_amt;
  logic             restock;
  logic             coin_ack;
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             busy;
  logic             change_done;
  logic             change_short;
  logic [7:0]       residual;
  logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;

  int tests_run;
  int tests_failed;

  // model inventory
  int mq, md, mn;
  int exp_coins[$];
  int exp_res;

  // observations from the last run_change
  int obs_coins[$];
  bit obs_done, obs_short, obs_stable, obs_to;
  int obs_res;
  int obs_valid_cycles;

  vm2002_change_ctrl #(
    .CNT_W   (CNT_W),
    .Q_INIT  (20),
    .D_INIT  (20),
    .N_INIT  (20),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .change_req   (change_req),
    .change_amt   (change_amt),
    .restock      (restock),
    .coin_ack     (coin_ack),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .busy         (busy),
    .change_done  (change_done),
    .change_short (change_short),
    .residual     (residual),
    .q_cnt        (q_cnt),
    .d_cnt        (d_cnt),
    .n_cnt        (n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Greedy change from the table of coin values, largest first.
  function automatic void model(input int amt);
    int val[3];
    int code[3];
    int cnt[3];
    int left;
    bit found;
    val  = '{5, 2, 1};
    code = '{3, 2, 1};
    cnt  = '{mq, md, mn};
    left = amt;
    exp_coins.delete();
    for (int k = 0; k < 300; k++) begin
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (!found && left >= val[i] && cnt[i] > 0) begin
          exp_coins.push_back(code[i]);
          cnt[i] -= 1;
          left -= val[i];
          found = 1'b1;
        end
      end
      if (!found) break;
    end
    exp_res = left;
    mq = cnt[0];
    md = cnt[1];
    mn = cnt[2];
  endfunction

  // Issue one request and act as the hopper until done/short.
  task automatic run_change(input int amt, input int delay,
                            input bit inject, input bit rs);
    int wcnt;
    int first;
    @(negedge clk);
    change_req = 1'b1;
    change_amt = amt[7:0];
    restock    = rs;
    obs_coins.delete();
    obs_done = 0;
    obs_short = 0;
    obs_stable = 1;
    obs_to = 1;
    obs_res = -1;
    obs_valid_cycles = 0;
    wcnt = 0;
    first = 0;
    @(negedge clk);
    change_req = 1'b0;
    restock    = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      change_req = 1'b0;
      if (coin_ack) begin
        coin_ack = 1'b0;
      end else if (coin_valid) begin
        obs_valid_cycles++;
        if (wcnt == 0) first = int'(coin_type);
        else if (int'(coin_type) != first) obs_stable = 0;
        if (inject && wcnt == delay / 2) change_req = 1'b1;
        if (wcnt == delay) begin
          coin_ack = 1'b1;
          obs_coins.push_back(int'(coin_type));
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (change_done || change_short) begin
        obs_done  = change_done;
        obs_short = change_short;
        obs_res   = int'(residual);
        obs_to    = 0;
        break;
      end
      @(negedge clk);
    end
    coin_ack   = 1'b0;
    change_req = 1'b0;
  endtask

  task automatic do_restock();
    @(negedge clk);
    restock = 1'b1;
    @(negedge clk);
    restock = 1'b0;
    mq = 20;
    md = 20;
    mn = 20;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (coin_valid !== 1'b0 || busy !== 1'b0 || change_done !== 1'b0 ||
        change_short !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: valid=%b busy=%b done=%b short=%b req=0000",
               coin_valid, busy, change_done, change_short);
    end
    tests_run++;
    if (coin_type !== 2'(NO_COINS) || residual !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_data: type=%0d res=%0d req=0/0",
               coin_type, residual);
    end
    tests_run++;
    if (q_cnt !== 6'd20 || d_cnt !== 6'd20 || n_cnt !== 6'd20) begin
      tests_failed++;
      $display("FAIL reset_cnt: %0d/%0d/%0d req=20/20/20",
               q_cnt, d_cnt, n_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq = 20;
    md = 20;
    mn = 20;
  endtask

  task automatic test_basic();
    int want[3];
    bit ok;
    want = '{3, 2, 1};
    run_change(8, 0, 0, 0);
    ok = (obs_coins.size() == 3);
    if (ok) for (int i = 0; i < 3; i++) if (obs_coins[i] != want[i]) ok = 0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_seq: got %p req Q,D,N", obs_coins);
    end
    tests_run++;
    if (obs_to || !obs_done || obs_short || obs_res != 0) begin
      tests_failed++;
      $display("FAIL basic_done: to=%0d done=%0d short=%0d res=%0d req done res0",
               obs_to, obs_done, obs_short, obs_res);
    end
    tests_run++;
    if (q_cnt !== 6'd19 || d_cnt !== 6'd19 || n_cnt !== 6'd19) begin
      tests_failed++;
      $display("FAIL basic_cnt: %0d/%0d/%0d req=19/19/19",
               q_cnt, d_cnt, n_cnt);
    end
    mq = 19;
    md = 19;
    mn = 19;
  endtask

  task automatic test_zero();
    bit seen_valid;
    seen_valid = 0;
    @(negedge clk);
    change_req = 1'b1;
    change_amt = 8'd0;
    @(negedge clk);
    change_req = 1'b0;
    if (coin_valid) seen_valid = 1;
    tests_run++;
    if (change_done !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_early: done=%b busy=%b req done=0 busy=1",
               change_done, busy);
    end
    @(negedge clk);
    if (coin_valid) seen_valid = 1;
    tests_run++;
    if (change_done !== 1'b1 || residual !== 8'd0) begin
      tests_failed++;
      $display("FAIL zero_done: done=%b res=%0d req done=1 res=0",
               change_done, residual);
    end
    @(negedge clk);
    tests_run++;
    if (seen_valid || change_done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_after: valid_seen=%0d done=%b busy=%b req 0/0/0",
               seen_valid, change_done, busy);
    end
  endtask

  task automatic test_short();
    int bad;
    do_restock();
    tests_run++;
    if (q_cnt !== 6'd20 || d_cnt !== 6'd20 || n_cnt !== 6'd20) begin
      tests_failed++;
      $display("FAIL restock_cnt: %0d/%0d/%0d req=20/20/20",
               q_cnt, d_cnt, n_cnt);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      run_change(1, $urandom_range(0, 2), 0, 0);
      if (obs_to || !obs_done || obs_coins.size() != 1) bad++;
      else if (obs_coins[0] != 1) bad++;
    end
    tests_run++;
    if (bad != 0 || n_cnt !== 6'd0) begin
      tests_failed++;
      $display("FAIL deplete_n: bad=%0d n=%0d req bad=0 n=0", bad, n_cnt);
    end
    run_change(6, 0, 0, 0);
    tests_run++;
    if (obs_coins.size() != 1 || obs_short != 1 || obs_done != 0 ||
        obs_res != 1) begin
      tests_failed++;
      $display("FAIL short6: coins=%p short=%0d done=%0d res=%0d req {3} 1 0 1",
               obs_coins, obs_short, obs_done, obs_res);
    end else if (obs_coins[0] != 3) begin
      tests_failed++;
      $display("FAIL short6: coin=%0d req 3", obs_coins[0]);
    end
    tests_run++;
    if (q_cnt !== 6'd19 || d_cnt !== 6'd20 || n_cnt !== 6'd0) begin
      tests_failed++;
      $display("FAIL short_cnt: %0d/%0d/%0d req=19/20/0",
               q_cnt, d_cnt, n_cnt);
    end
    mq = 19;
    md = 20;
    mn = 0;
  endtask

  task automatic test_hold();
    int q0;
    q0 = mq;
    run_change(5, 10, 1, 0);
    tests_run++;
    if (!obs_stable || obs_valid_cycles != 11 || obs_coins.size() != 1) begin
      tests_failed++;
      $display("FAIL hold_wait: stable=%0d vcyc=%0d n=%0d req 1 11 1",
               obs_stable, obs_valid_cycles, obs_coins.size());
    end else if (obs_coins[0] != 3) begin
      tests_failed++;
      $display("FAIL hold_wait: coin=%0d req 3", obs_coins[0]);
    end
    tests_run++;
    if (!obs_done || int'(q_cnt) != q0 - 1) begin
      tests_failed++;
      $display("FAIL hold_dec: done=%0d q=%0d req 1 %0d",
               obs_done, q_cnt, q0 - 1);
    end
    mq = q0 - 1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || coin_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_noqueue: busy=%b valid=%b req 0 0",
               busy, coin_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit pulse;
    bit got;
    pulse = 0;
    got = 0;
    @(negedge clk);
    change_req = 1'b1;
    change_amt = 8'd5;
    @(negedge clk);
    change_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (coin_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL rmid_valid: coin_valid never rose req 1");
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (coin_valid !== 1'b0 || busy !== 1'b0 ||
        q_cnt !== 6'd20 || d_cnt !== 6'd20 || n_cnt !== 6'd20) begin
      tests_failed++;
      $display("FAIL rmid_reset: valid=%b busy=%b cnt=%0d/%0d/%0d req 0 0 20/20/20",
               coin_valid, busy, q_cnt, d_cnt, n_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq = 20;
    md = 20;
    mn = 20;
    repeat (5) begin
      @(negedge clk);
      if (change_done || change_short || busy) pulse = 1;
    end
    tests_run++;
    if (pulse) begin
      tests_failed++;
      $display("FAIL rmid_pulse: saw done/short/busy after reset req none");
    end
  endtask

  task automatic test_random();
    int amt, dly;
    bit rs;
    bit ok;
    for (int n = 0; n < 30; n++) begin
      amt = $urandom_range(0, 40);
      dly = $urandom_range(0, 3);
      rs  = ($urandom_range(0, 3) == 0);
      if (rs) begin
        mq = 20;
        md = 20;
        mn = 20;
      end
      model(amt);
      run_change(amt, dly, 0, rs);
      ok = (obs_coins.size() == exp_coins.size());
      if (ok) foreach (exp_coins[i]) if (obs_coins[i] != exp_coins[i]) ok = 0;
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL rnd_seq[%0d] amt=%0d: got %p req %p",
                 n, amt, obs_coins, exp_coins);
      end
      tests_run++;
      if (obs_to || obs_done != (exp_res == 0) ||
          obs_short != (exp_res != 0) || obs_res != exp_res) begin
        tests_failed++;
        $display("FAIL rnd_end[%0d] amt=%0d: to=%0d done=%0d short=%0d res=%0d req res=%0d",
                 n, amt, obs_to, obs_done, obs_short, obs_res, exp_res);
      end
      tests_run++;
      if (int'(q_cnt) != mq || int'(d_cnt) != md || int'(n_cnt) != mn) begin
        tests_failed++;
        $display("FAIL rnd_cnt[%0d]: %0d/%0d/%0d req %0d/%0d/%0d",
                 n, q_cnt, d_cnt, n_cnt, mq, md, mn);
      end
    end
  endtask

`ifdef VM2002_HOPPER_TIMEOUT_EN
  task automatic test_timeout();
    int d0;
    do_restock();
    d0 = md;
    run_change(2, 100000, 0, 0);
    tests_run++;
    if (obs_to || !obs_short || obs_res != 2 || obs_valid_cycles != TMO ||
        obs_coins.size() != 0) begin
      tests_failed++;
      $display("FAIL timeout: to=%0d short=%0d res=%0d vcyc=%0d acks=%0d req 0 1 2 %0d 0",
               obs_to, obs_short, obs_res, obs_valid_cycles,
               obs_coins.size(), TMO);
    end
    tests_run++;
    if (int'(d_cnt) != d0) begin
      tests_failed++;
      $display("FAIL timeout_cnt: d=%0d req %0d", d_cnt, d0);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    change_req = 1'b0;
    change_amt = 8'd0;
    restock    = 1'b0;
    coin_ack   = 1'b0;
    mq = 20;
    md = 20;
    mn = 20;
    test_reset();
    test_basic();
    test_zero();
    test_short();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef VM2002_HOPPER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vm2002_change_ctrl.md
Name: vm2002_change_ctrl

Overview:
Sequences change dispensing for the vending machine after a sale or a coin-return request. It takes a change amount from the main FSM, picks coins greedily (quarter, then dime, then nickel) against its own per-coin inventory, and drives a coin hopper one coin at a time over a valid/ack handshake. It reports completion, or a shortfall when the inventory cannot cover the amount. It sits between the vending FSM (DISPENSE_ITEM / coin return) and the hopper.

Parameters:
CNT_W, 6, width of each coin inventory counter
Q_INIT, 20, quarter count loaded at reset and on restock
D_INIT, 20, dime count loaded at reset and on restock
N_INIT, 20, nickel count loaded at reset and on restock
TIMEOUT, 64, hopper ack timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
change_req  in  1  single-cycle request to dispense change_amt
change_amt  in  8  change due, in nickel units (1 = $0.05); sampled only when the request is accepted
restock  in  1  single-cycle pulse; reloads all inventory counters to their *_INIT values
coin_ack  in  1  hopper has taken the coin currently presented
coin_valid  out  1  a coin is presented to the hopper
coin_type  out  2  coins_t value of the presented coin
busy  out  1  high whenever the FSM is not in C_IDLE
change_done  out  1  one-cycle pulse; the full amount was dispensed
change_short  out  1  one-cycle pulse; dispensing stopped with residual > 0
residual  out  8  amount left undispensed; valid from the done/short pulse until the next accepted request
q_cnt, d_cnt, n_cnt  out  CNT_W each  current coin inventory

Behaviour:
- Reset (async, rst_n=0): FSM goes to C_IDLE. coin_valid=0, coin_type=NO_COINS, busy=0, change_done=0, change_short=0, residual=0. Counters load Q_INIT/D_INIT/N_INIT. An operation in flight is dropped; no pulse is emitted.
- States, one-hot: C_IDLE, C_SELECT, C_DISPENSE, C_DONE, C_SHORT.
- C_IDLE: on change_req, latch change_amt into rem and go to C_SELECT. change_req is ignored in every other state and is not queued.
- restock is honoured only in C_IDLE and ignored elsewhere. If restock and change_req arrive in the same cycle, the reload takes effect first, and the first C_SELECT sees the reloaded counts.
- C_SELECT is one cycle, first match wins:
  - rem==0 -> C_DONE
  - rem>=5 and q_cnt>0 -> QUARTER
  - rem>=2 and d_cnt>0 -> DIME
  - rem>=1 and n_cnt>0 -> NICKEL
  - no match -> C_SHORT
  - When a coin is chosen, register coin_type and go to C_DISPENSE.
- Greedy selection is final: no backtracking. Example: rem=6 with no nickels dispenses Q, then shorts with residual 1.
- C_DISPENSE: coin_valid=1 and coin_type is held stable until coin_ack. On the ack cycle:
  - subtract the coin value (Q=5, D=2, N=1) from rem
  - decrement the matching counter
  - return to C_SELECT
  - coin_valid drops the cycle after the ack.
  - coin_ack outside C_DISPENSE is ignored.
- C_DONE: change_done=1 for one cycle, residual=0, then C_IDLE.
- C_SHORT: change_short=1 for one cycle, residual=rem, then C_IDLE.
- Latency:
  - change_amt=0: change_done asserts 2 cycles after the req cycle.
  - Each coin takes 1 select cycle plus the ack wait (minimum 1 cycle).
- Arithmetic: rem is 8 bits unsigned. Underflow is impossible by the selection rule. Counters never decrement below 0 because a zero-count coin is never selected.

Optional Feature:
Macro: VM2002_HOPPER_TIMEOUT_EN.
- Defined: a cycle counter runs while in C_DISPENSE. If TIMEOUT cycles pass without coin_ack, drop coin_valid, do not decrement anything, and go to C_SHORT with residual = current rem.
- Undefined: C_DISPENSE waits for coin_ack indefinitely, and no timeout logic is synthesised.

Decomposition:
- Add to vm2002_common_pkg:
  - the chg_state_t one-hot enum with a matching index enum, mirroring fsm_state_t
  - coin values in nickel units: NICKEL_UNITS=1, DIME_UNITS=2, QUARTER_UNITS=5
- coins_t is reused for coin_type.
- One sub-module: vm2002_coin_inventory, holding the three counters with restock load, a decrement on a one-hot coin strobe, and nonzero flags.

Test Plan:
1. Reset, then req amt=8 (40c) with full inventory -> Q, D, N presented in that order (ack after 1 cycle each); change_done; q/d/n = 19/19/19.
2. Req amt=0 -> change_done 2 cycles after req, coin_valid never asserts.
3. Restock, then deplete nickels to 0 (amt=1, repeated 20 times), then req amt=6 -> one Q dispensed, change_short, residual=1.
4. Req amt=5; hold coin_ack low for 10 cycles, then high -> coin_type=QUARTER stable throughout, one decrement only; a second change_req issued mid-wait is ignored.
5. Assert rst_n=0 while in C_DISPENSE -> coin_valid=0 immediately, counters reload to 20, no done/short pulse.
6. With VM2002_HOPPER_TIMEOUT_EN defined and TIMEOUT=64: req amt=2 with coin_ack never asserted -> change_short at cycle 64 of the wait, residual=2, d_cnt unchanged.
